// File: rtl/flght_seq.sv
// flght_seq: flight-mode sequencer (IDLE/CAL/FLY/LAND/FAULT) driving inertial_cal, slew-limited thrst, mtrs_en.
// Latency: 1 cycle from sampled input to registered state/outputs; thrust steps 1 LSB per RAMP_DIV cycles.
// Backpressure: none; level/pulse inputs are sampled every cycle. Optional FLGHT_SEQ_WDOG_EN adds a FLY command watchdog.
module flght_seq #(
  parameter int RAMP_DIV    = 1024,
  parameter int CAL_TIMEOUT = 10_000_000,
  parameter int WDOG_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strt_cal,
  input  logic       cal_done,
  input  logic       motors_off,
  input  logic       batt_low,
  input  logic       cmd_vld,
  input  logic [8:0] thrst_cmd,
  output logic       inertial_cal,
  output logic [8:0] thrst,
  output logic       mtrs_en,
  output logic       cal_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAL   = 3'd1,
    S_FLY   = 3'd2,
    S_LAND  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam int PW = $clog2(RAMP_DIV);
  localparam int CW = $clog2(CAL_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [CW-1:0] CAL_LAST   = CW'(CAL_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [8:0]    thrst_q, thrst_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cal_cnt_q, cal_cnt_d;
  logic          tick;
  logic          cal_to;
  logic          wdog_to;

  // The prescaler only runs in the ramping states, so the tick is gated by state
  assign tick   = ((state_q == S_FLY) || (state_q == S_LAND)) && (presc_q == PRESC_LAST);
  assign cal_to = (state_q == S_CAL) && (cal_cnt_q == CAL_LAST);

`ifdef FLGHT_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wd_q, wd_d;

  assign wdog_to = (state_q == S_FLY) && (wd_q == WDOG_LAST);

  // Watchdog counts FLY cycles since FLY entry or the most recent host command
  always_comb begin
    wd_d = '0;
    if ((state_q == S_FLY) && (state_d == S_FLY) && !cmd_vld) wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_wdog;
  assign wdog_to     = 1'b0;
  assign unused_wdog = cmd_vld ^ (WDOG_CYCLES > 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: motors_off beats timeout/batt_low/watchdog, which beat cal_done, which beats strt_cal;
  // cal_done on the timeout terminal count still wins so a late calibration is not thrown away
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (strt_cal) state_d = S_CAL;
      S_CAL: begin
        if (motors_off)    state_d = S_IDLE;
        else if (cal_done) state_d = S_FLY;
        else if (cal_to)   state_d = S_FAULT;
      end
      S_FLY:   if (motors_off || batt_low || wdog_to) state_d = S_LAND;
      S_LAND:  if (thrst_q == 9'd0) state_d = S_IDLE;
      S_FAULT: if (motors_off) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: counters restart whenever the state changes, thrust slews on ticks only
  always_comb begin
    thrst_d   = thrst_q;
    presc_d   = '0;
    cal_cnt_d = '0;
    case (state_q)
      S_CAL: if (state_d == S_CAL) cal_cnt_d = cal_cnt_q + 1'b1;
      S_FLY: begin
        if (state_d == S_FLY) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (thrst_q < thrst_cmd)      thrst_d = thrst_q + 9'd1;
            else if (thrst_q > thrst_cmd) thrst_d = thrst_q - 9'd1;
          end
        end
      end
      S_LAND: begin
        // Staying in LAND implies thrst_q is non-zero, so the decrement cannot wrap
        if (state_d == S_LAND) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) thrst_d = thrst_q - 9'd1;
        end
      end
      default: ;
    endcase
    if ((state_d == S_IDLE) || (state_d == S_CAL) || (state_d == S_FAULT)) thrst_d = 9'd0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thrst_q   <= 9'd0;
      presc_q   <= '0;
      cal_cnt_q <= '0;
    end else begin
      thrst_q   <= thrst_d;
      presc_q   <= presc_d;
      cal_cnt_q <= cal_cnt_d;
    end
  end

  // Output decode straight from registered state so outputs and state move on the same edge
  always_comb begin
    state        = state_q;
    thrst        = thrst_q;
    inertial_cal = (state_q == S_CAL);
    mtrs_en      = (state_q == S_CAL) || (state_q == S_FLY) || (state_q == S_LAND);
    cal_err      = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_flght_seq.sv
`timescale 1ns/1ps
module tb_flght_seq;

  localparam int RD = 4;
  localparam int CT = 100;
  localparam int WD = 50;

  localparam int M_IDLE  = 0;
  localparam int M_CAL   = 1;
  localparam int M_FLY   = 2;
  localparam int M_LAND  = 3;
  localparam int M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       strt_cal = 1'b0, cal_done = 1'b0, motors_off = 1'b0, batt_low = 1'b0, cmd_vld = 1'b0;
  logic [8:0] thrst_cmd = 9'd0;
  logic       inertial_cal, mtrs_en, cal_err;
  logic [8:0] thrst;
  logic [2:0] state;

  flght_seq #(.RAMP_DIV(RD), .CAL_TIMEOUT(CT), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .cal_done(cal_done),
    .motors_off(motors_off), .batt_low(batt_low), .cmd_vld(cmd_vld), .thrst_cmd(thrst_cmd),
    .inertial_cal(inertial_cal), .thrst(thrst), .mtrs_en(mtrs_en), .cal_err(cal_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] thr;
    logic       ic;
    logic       me;
    logic       ce;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";
  exp_t  sb_q[$];

  // Reference model: mode, thrust and the edge count at which the mode was entered
  int m_mode = M_IDLE;
  int m_thr  = 0;
  int m_n    = 0;
  int m_entry = 0;
  int m_wref  = 0;

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a.st = state; a.thr = thrst; a.ic = inertial_cal; a.me = mtrs_en; a.ce = cal_err;
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s [%s] @%0t: got st=%0d thrst=%0d ical=%0b men=%0b cerr=%0b, want st=%0d thrst=%0d ical=%0b men=%0b cerr=%0b",
                 name, phase, $time, a.st, a.thr, a.ic, a.me, a.ce, e.st, e.thr, e.ic, e.me, e.ce);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st  = 3'(m_mode);
    e.thr = 9'(m_thr);
    e.ic  = (m_mode == M_CAL);
    e.me  = (m_mode == M_CAL) || (m_mode == M_FLY) || (m_mode == M_LAND);
    e.ce  = (m_mode == M_FAULT);
    return e;
  endfunction

  task automatic enter(input int md);
    m_mode  = md;
    m_entry = m_n;
  endtask

  // One clock edge of the reference: ramp ticks fall on multiples of RD edges after entry,
  // the calibration timeout on edge CT after entry, the watchdog WD edges after the last kick
  task automatic model_step();
    int a;
    bit wd;
    m_n++;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_thr  = 0;
      return;
    end
    a  = m_n - m_entry;
    wd = 1'b0;
`ifdef FLGHT_SEQ_WDOG_EN
    wd = (m_mode == M_FLY) && ((m_n - m_wref) == WD);
`endif
    case (m_mode)
      M_IDLE: if (strt_cal) enter(M_CAL);
      M_CAL: begin
        if (motors_off)    enter(M_IDLE);
        else if (cal_done) begin enter(M_FLY); m_wref = m_n; end
        else if (a == CT)  enter(M_FAULT);
      end
      M_FLY: begin
        if (motors_off || batt_low || wd) enter(M_LAND);
        else begin
          if (a % RD == 0) begin
            if (m_thr < int'(thrst_cmd))      m_thr++;
            else if (m_thr > int'(thrst_cmd)) m_thr--;
          end
          if (cmd_vld) m_wref = m_n;
        end
      end
      M_LAND: begin
        if (m_thr == 0)       enter(M_IDLE);
        else if (a % RD == 0) m_thr--;
      end
      M_FAULT: if (motors_off) enter(M_IDLE);
      default: enter(M_IDLE);
    endcase
    if (m_mode == M_IDLE || m_mode == M_CAL || m_mode == M_FAULT) m_thr = 0;
  endtask

  // Monitor: every output cycle is compared against the oldest pending expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) compare("cycle", sb_q.pop_front());
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    sb_q.push_back(model_out());
    #1;
    strt_cal   = 1'b0;
    cal_done   = 1'b0;
    motors_off = 1'b0;
    cmd_vld    = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic launch();
    strt_cal = 1'b1; cyc();
    cal_done = 1'b1; cyc();
  endtask

  initial begin
    exp_t z;
    z = '0;
    #2 rst_n = 1'b0;
    #1 compare("reset_async_start", z);
    run(3);
    rst_n = 1'b1;
    run(2);

    phase = "cal_to_fly";
    strt_cal = 1'b1; cyc();
    run(5);
    cal_done = 1'b1; cyc();

    phase = "ramp_up_down";
    thrst_cmd = 9'd10; run(45);
    thrst_cmd = 9'd7;  run(15);

    phase = "land";
    thrst_cmd = 9'd5; run(20);
    motors_off = 1'b1; cyc();
    run(25);

    phase = "cal_timeout";
    strt_cal = 1'b1; cyc();
    run(102);
    strt_cal = 1'b1; cyc();
    run(3);
    motors_off = 1'b1; cyc();
    run(2);

    phase = "cal_done_at_timeout";
    strt_cal = 1'b1; cyc();
    run(99);
    cal_done = 1'b1; cyc();
    run(2);
    motors_off = 1'b1; cyc();
    run(3);

    phase = "motors_off_beats_cal_done";
    strt_cal = 1'b1; cyc();
    run(2);
    cal_done = 1'b1; motors_off = 1'b1; cyc();
    run(2);

    phase = "batt_low";
    launch();
    thrst_cmd = 9'd3; run(20);
    batt_low = 1'b1; cyc();
    batt_low = 1'b0; run(20);

    phase = "saturate_and_async_reset";
    launch();
    thrst_cmd = 9'd511; run(2100);
    strt_cal = 1'b1; cyc();
    thrst_cmd = 9'd200; run(1300);
    motors_off = 1'b1; cyc();
    strt_cal = 1'b1; cyc();
    run(30);
    #1 rst_n = 1'b0;
    #1 compare("reset_async_mid_land", z);
    sb_q.delete();
    m_mode = M_IDLE;
    m_thr  = 0;
    run(2);
    rst_n = 1'b1;
    run(3);

`ifdef FLGHT_SEQ_WDOG_EN
    phase = "watchdog_kicked";
    launch();
    thrst_cmd = 9'd20;
    for (int k = 0; k < 5; k++) begin
      run(39);
      cmd_vld = 1'b1; cyc();
    end
    phase = "watchdog_expire";
    run(60);
    run(100);
`endif

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      strt_cal   = ($urandom % 50) == 0;
      cal_done   = ($urandom % 30) == 0;
      motors_off = ($urandom % 150) == 0;
      batt_low   = ($urandom % 400) == 0;
      cmd_vld    = ($urandom % 20) == 0;
      if (($urandom % 60) == 0) thrst_cmd = 9'($urandom_range(0, 511));
      cyc();
    end
    batt_low = 1'b0;

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
